// File: rtl/burst_gen_if.sv
// rtl/burst_gen_if.sv - sample stream bundle between burst_gen and its consumer
interface burst_gen_if;
    logic [31:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/burst_gen.sv
// rtl/burst_gen.sv - skip/burst/gap sample sequencer; BURST_GEN_RAMP_EN adds a 3-word amplitude ramp
module burst_gen #(
    parameter int CNT_W = 16,
    parameter int NB_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       amplitude,
    input  logic [CNT_W-1:0]  skip,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [CNT_W-1:0]  gap_len,
    input  logic [NB_W-1:0]   nb_bursts,
    burst_gen_if.master       sample_if,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_BURST,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_W-1:0]    bursts_left_q, bursts_left_d;
    logic signed [15:0] amp_q, amp_d;
    logic [CNT_W-1:0]   skip_len_q, skip_len_d;
    logic [CNT_W-1:0]   burst_len_q, burst_len_d;
    logic [CNT_W-1:0]   gap_len_q, gap_len_d;
    logic               done_q, done_d;

    logic               accept;
    logic               skip_last;
    logic               burst_last;
    logic               gap_last;
    logic signed [15:0] mag;
    logic signed [15:0] i_word;

    // Negating -32768 would wrap back to itself; clamp to the largest positive value.
    function automatic logic signed [15:0] sat_neg(input logic signed [15:0] x);
        if (x == 16'sh8000) begin
            return 16'sh7FFF;
        end
        return -x;
    endfunction

    always_comb begin
        sample_if.sample_valid = enable && (state_q != ST_IDLE);
        accept     = sample_if.sample_valid && sample_if.sample_ready;
        skip_last  = (cnt_q == skip_len_q - 1'b1);
        burst_last = (cnt_q == burst_len_q - 1'b1);
        gap_last   = (cnt_q == gap_len_q - 1'b1);
    end

    always_comb begin
`ifdef BURST_GEN_RAMP_EN
        if (cnt_q == '0) begin
            mag = amp_q >>> 3;
        end else if (cnt_q == CNT_W'(1)) begin
            mag = amp_q >>> 2;
        end else if (cnt_q == CNT_W'(2)) begin
            mag = amp_q >>> 1;
        end else begin
            mag = amp_q;
        end
`else
        mag = amp_q;
`endif
        // Even word index within a burst is +A, odd is -A.
        i_word = cnt_q[0] ? sat_neg(mag) : mag;
        if (state_q == ST_BURST) begin
            sample_if.sample = {i_word, 16'h0000};
        end else begin
            sample_if.sample = 32'h0000_0000;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bursts_left_d = bursts_left_q;
        amp_d         = amp_q;
        skip_len_d    = skip_len_q;
        burst_len_d   = burst_len_q;
        gap_len_d     = gap_len_q;
        done_d        = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && start && (burst_len != '0) && (nb_bursts != '0)) begin
                        amp_d         = amplitude;
                        skip_len_d    = skip;
                        burst_len_d   = burst_len;
                        gap_len_d     = gap_len;
                        bursts_left_d = nb_bursts;
                        cnt_d         = '0;
                        state_d       = (skip == '0) ? ST_BURST : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (accept) begin
                        if (skip_last) begin
                            cnt_d   = '0;
                            state_d = ST_BURST;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        if (burst_last) begin
                            cnt_d = '0;
                            if (bursts_left_q == NB_W'(1)) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                bursts_left_d = bursts_left_q - 1'b1;
                                state_d       = (gap_len_q != '0) ? ST_GAP : ST_BURST;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (accept) begin
                        if (gap_last) begin
                            cnt_d   = '0;
                            state_d = ST_BURST;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bursts_left_q <= '0;
            amp_q         <= '0;
            skip_len_q    <= '0;
            burst_len_q   <= '0;
            gap_len_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bursts_left_q <= bursts_left_d;
            amp_q         <= amp_d;
            skip_len_q    <= skip_len_d;
            burst_len_q   <= burst_len_d;
            gap_len_q     <= gap_len_d;
            done_q        <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_burst_gen.sv
// tb/tb_burst_gen.sv - scoreboard bench for burst_gen against a word-list reference model
module tb_burst_gen;
    localparam int CNT_W = 16;
    localparam int NB_W  = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      amplitude = '0;
    logic [CNT_W-1:0] skip = '0;
    logic [CNT_W-1:0] burst_len = '0;
    logic [CNT_W-1:0] gap_len = '0;
    logic [NB_W-1:0]  nb_bursts = '0;
    logic             busy;
    logic             done;

    burst_gen_if sif ();

    burst_gen #(.CNT_W(CNT_W), .NB_W(NB_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .abort     (abort),
        .amplitude (amplitude),
        .skip      (skip),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .nb_bursts (nb_bursts),
        .sample_if (sif.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        pending_done = 1'b0;
    logic        pending_idle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_sample = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: I value of word k of a burst, from the amplitude rules in plain integer arithmetic.
    function automatic logic [15:0] burst_word(input int amp, input int k);
        int mag;
        int v;
`ifdef BURST_GEN_RAMP_EN
        if (k < 3) mag = amp >>> (3 - k);
        else       mag = amp;
`else
        mag = amp;
`endif
        v = (k % 2 == 1) ? -mag : mag;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic push_seq(input int amp, input int sk, input int bl, input int gl, input int nb);
        for (int i = 0; i < sk; i++) exp_q.push_back(32'h0);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < bl; k++) exp_q.push_back({burst_word(amp, k), 16'h0000});
            if (b != nb - 1) begin
                for (int g = 0; g < gl; g++) exp_q.push_back(32'h0);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            pending_done = 1'b0;
            pending_idle = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            check("done_pulse", {31'b0, done}, {31'b0, pending_done});
            if (pending_done) check("busy_at_done", {31'b0, busy}, 32'h0);
            pending_done = 1'b0;
            if (pending_idle) begin
                check("abort_valid", {31'b0, sif.sample_valid}, 32'h0);
                check("abort_busy", {31'b0, busy}, 32'h0);
                pending_idle = 1'b0;
            end
            if (prev_stall && sif.sample_valid) check("stall_stable", sif.sample, prev_sample);
            if (sif.sample_valid && sif.sample_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_word: got %h expected no word", sif.sample);
                end else begin
                    check("word", sif.sample, exp_q.pop_front());
                    if (exp_q.size() == 0 && !abort) pending_done = 1'b1;
                end
            end
            if (abort) begin
                exp_q.delete();
                pending_idle = 1'b1;
            end
            prev_stall  = sif.sample_valid && !sif.sample_ready;
            prev_sample = sif.sample;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_seq(input logic [15:0] amp, input int sk, input int bl, input int gl,
                           input int nb, input int rmode, input int abort_after,
                           input bit rand_en, input bit busy_start);
        int  acc;
        bit  finished;
        acc = 0;
        finished = 1'b0;
        amplitude = amp;
        skip      = CNT_W'(sk);
        burst_len = CNT_W'(bl);
        gap_len   = CNT_W'(gl);
        nb_bursts = NB_W'(nb);
        enable    = 1'b1;
        start     = 1'b1;
        push_seq(int'($signed(amp)), sk, bl, gl, nb);
        step();
        start = 1'b0;
        amplitude = 16'($urandom);
        skip      = CNT_W'($urandom_range(0, 7));
        burst_len = CNT_W'($urandom_range(0, 7));
        gap_len   = CNT_W'($urandom_range(0, 7));
        nb_bursts = NB_W'($urandom_range(0, 7));
        for (int c = 0; c < 3000; c++) begin
            case (rmode)
                0:       sif.sample_ready = 1'b1;
                1:       sif.sample_ready = (c % 2 == 0);
                default: sif.sample_ready = ($urandom_range(0, 2) != 0);
            endcase
            enable = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            start  = busy_start && (c == 2);
            #1;
            if (sif.sample_valid && sif.sample_ready) begin
                acc++;
                if (acc == abort_after) abort = 1'b1;
            end
            @(posedge clock);
            #1;
            abort = 1'b0;
            if (busy_start && c == 2) check("busy_after_restart", {31'b0, busy}, 32'h1);
            start = 1'b0;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL seq_timeout: busy still %0b after cycle budget", busy);
        end
        sif.sample_ready = 1'b1;
        enable = 1'b1;
        step();
        step();
        check("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        sif.sample_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {31'b0, sif.sample_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_sample", sif.sample, 32'h0);
        reset_n = 1'b1;
        step();

        run_seq(16'd1000, 2, 3, 2, 2, 0, -1, 1'b0, 1'b0);
        run_seq(16'd1000, 2, 3, 2, 2, 1, -1, 1'b0, 1'b0);
        run_seq(16'h8000, 0, 2, 0, 1, 0, -1, 1'b0, 1'b0);
        run_seq(16'd1000, 2, 3, 2, 2, 0, 4, 1'b0, 1'b0);
        run_seq(16'd800, 0, 5, 1, 2, 2, -1, 1'b0, 1'b0);
        run_seq(16'hF000, 1, 2, 0, 3, 2, -1, 1'b1, 1'b0);
        run_seq(16'd1234, 1, 4, 2, 2, 2, -1, 1'b1, 1'b1);

        enable = 1'b1;
        amplitude = 16'd55;
        skip = CNT_W'(1);
        burst_len = CNT_W'(3);
        gap_len = CNT_W'(1);
        nb_bursts = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("nb0_busy", {31'b0, busy}, 32'h0);
        nb_bursts = NB_W'(2);
        burst_len = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("bl0_busy", {31'b0, busy}, 32'h0);
        step();
        check("ignored_valid", {31'b0, sif.sample_valid}, 32'h0);

        for (int r = 0; r < 12; r++) begin
            run_seq(16'($urandom), $urandom_range(0, 3), $urandom_range(1, 5),
                    $urandom_range(0, 3), $urandom_range(1, 3), 2, -1, 1'b1, 1'b0);
        end

        amplitude = 16'd300;
        skip = CNT_W'(1);
        burst_len = CNT_W'(4);
        gap_len = CNT_W'(2);
        nb_bursts = NB_W'(3);
        push_seq(300, 1, 4, 2, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        #2;
        check("midrst_valid", {31'b0, sif.sample_valid}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_sample", sif.sample, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        step();
        check("postrst_busy", {31'b0, busy}, 32'h0);
        check("postrst_done", {31'b0, done}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
